// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package soc_system_sysid_pkg;

    // Checker sequence: request ID word, await it, request timestamp, await it, report.
    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        FIN
    } sysid_state_e;

    // Word addresses inside the sysid control slave.
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/soc_system_sysid_timeout.sv
// Per-transaction watchdog for the system-ID checker.
// Only instantiated when SYSID_CHECKER_TIMEOUT_EN is defined.
module soc_system_sysid_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    // At least 8 bits so the counter matches the documented minimum width.
    localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count cycles spent in a request/wait state; cleared when a new request begins.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires during the LIMIT-th counted cycle of the current transaction.
    assign expire = count && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against expected values. Runs once after reset (AUTO_START)
// and again on every start request seen while idle.
// Optional per-transaction timeout: define SYSID_CHECKER_TIMEOUT_EN.
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'hACD5_1302,
    parameter logic [31:0] EXP_TS         = 32'h58AF_E666,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timed_out,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sysid_state_e state_q;
    logic         auto_arm_q;
    logic         addr_q;
    logic         read_q;
    logic         busy_q;
    logic         done_q;
    logic         id_ok_q;
    logic         ts_ok_q;
    logic         timed_out_q;
    logic [31:0]  id_value_q;
    logic [31:0]  ts_value_q;

    logic accept;
    logic launch;
    logic expire;

    assign accept = read_q && !avm_waitrequest;
    assign launch = start || auto_arm_q;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic ts_entry;
    logic tmo_load;
    logic tmo_count;

    // Entering TS_REQ, either from ID_WAIT or straight from a same-cycle ID response.
    assign ts_entry  = ((state_q == ID_REQ) && accept && avm_readdatavalid) ||
                       ((state_q == ID_WAIT) && avm_readdatavalid);
    assign tmo_load  = ((state_q == IDLE) && launch) || ts_entry;
    assign tmo_count = (state_q == ID_REQ) || (state_q == ID_WAIT) ||
                       (state_q == TS_REQ) || (state_q == TS_WAIT);

    soc_system_sysid_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .load   (tmo_load),
        .count  (tmo_count),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Checker FSM with registered bus and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            auto_arm_q  <= AUTO_START;
            addr_q      <= SYSID_ADDR_ID;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            timed_out_q <= 1'b0;
            id_value_q  <= '0;
            ts_value_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        auto_arm_q  <= 1'b0;
                        id_ok_q     <= 1'b0;
                        ts_ok_q     <= 1'b0;
                        timed_out_q <= 1'b0;
                        busy_q      <= 1'b1;
                        read_q      <= 1'b1;
                        addr_q      <= SYSID_ADDR_ID;
                        state_q     <= ID_REQ;
                    end
                end
                ID_REQ: begin
                    if (accept) begin
                        if (avm_readdatavalid) begin
                            // Same-cycle response: capture and issue the timestamp read at once.
                            id_value_q <= avm_readdata;
                            id_ok_q    <= (avm_readdata == EXP_ID);
                            addr_q     <= SYSID_ADDR_TS;
                            state_q    <= TS_REQ;
                        end else begin
                            read_q  <= 1'b0;
                            state_q <= ID_WAIT;
                        end
                    end else if (expire) begin
                        timed_out_q <= 1'b1;
                        read_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                ID_WAIT: begin
                    if (avm_readdatavalid) begin
                        id_value_q <= avm_readdata;
                        id_ok_q    <= (avm_readdata == EXP_ID);
                        read_q     <= 1'b1;
                        addr_q     <= SYSID_ADDR_TS;
                        state_q    <= TS_REQ;
                    end else if (expire) begin
                        timed_out_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                TS_REQ: begin
                    if (accept) begin
                        read_q <= 1'b0;
                        if (avm_readdatavalid) begin
                            ts_value_q <= avm_readdata;
                            ts_ok_q    <= (avm_readdata == EXP_TS);
                            done_q     <= 1'b1;
                            state_q    <= FIN;
                        end else begin
                            state_q <= TS_WAIT;
                        end
                    end else if (expire) begin
                        timed_out_q <= 1'b1;
                        read_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                TS_WAIT: begin
                    if (avm_readdatavalid) begin
                        ts_value_q <= avm_readdata;
                        ts_ok_q    <= (avm_readdata == EXP_TS);
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end else if (expire) begin
                        timed_out_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                FIN: begin
                    // done is high during this state; busy drops on the following cycle.
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    read_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timed_out   = timed_out_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Scoreboard bench for soc_system_sysid_checker: a reactive Avalon slave model
// answers reads, stimulus pushes the expected status of each check, and a
// monitor compares on every done pulse.
module tb_soc_system_sysid_checker;

    localparam logic [31:0] ID_WORD = 32'hACD5_1302;
    localparam logic [31:0] TS_WORD = 32'h58AF_E666;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        timed_out;
        logic [31:0] id_value;
        logic [31:0] ts_value;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timed_out;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    exp_t        exp_q[$];

    // Slave model configuration (written only by the stimulus process).
    int          cfg_wait = 0;
    bit          cfg_same = 1'b1;
    bit          cfg_resp_ts = 1'b1;
    logic [31:0] cfg_id = ID_WORD;
    logic [31:0] cfg_ts = TS_WORD;
    int          inject_until = 0;
    logic [31:0] inject_data = '0;

    soc_system_sysid_checker #(
        .EXP_ID         (ID_WORD),
        .EXP_TS         (TS_WORD),
        .TIMEOUT_CYCLES (16),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timed_out         (timed_out),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    always #5 clock = ~clock;

    initial begin : cycle_counter
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic iok, input logic tok, input logic tmo,
                            input logic [31:0] idv, input logic [31:0] tsv);
        exp_t e;
        e.id_ok     = iok;
        e.ts_ok     = tok;
        e.timed_out = tmo;
        e.id_value  = idv;
        e.ts_value  = tsv;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int i = 0;
        while (done_cnt <= n && i < budget) begin
            @(posedge clock);
            #2;
            i++;
        end
        if (done_cnt <= n) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within %0d cycles (got %0d pulses, expected %0d)",
                     name, budget, done_cnt - n, 1);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Reactive Avalon slave: stalls cfg_wait cycles, then answers by address.
    initial begin : slave
        int          stall;
        logic        pend;
        logic [31:0] pend_data;
        logic [31:0] rd;
        stall = 0;
        pend = 1'b0;
        pend_data = '0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        forever begin
            @(negedge clock);
            #1;
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            if (cyc < inject_until) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = inject_data;
            end else if (pend) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = pend_data;
                pend = 1'b0;
            end
            if (avm_read && !reset) begin
                if (stall < cfg_wait) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                end else begin
                    stall = 0;
                    if (!avm_address || cfg_resp_ts) begin
                        rd = avm_address ? cfg_ts : cfg_id;
                        if (cfg_same) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata = rd;
                        end else begin
                            pend = 1'b1;
                            pend_data = rd;
                        end
                    end
                end
            end else begin
                stall = 0;
            end
        end
    end

    // Scoreboard: compare status on every done pulse.
    initial begin : scoreboard
        exp_t e;
        bit   chk_next = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (chk_next) begin
                check("busy_low_after_done", {31'd0, busy}, 32'd0);
                check("done_one_cycle", {31'd0, done}, 32'd0);
                chk_next = 1'b0;
            end
            if (done) begin
                done_cnt++;
                chk_next = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done pulse, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_id_ok", {31'd0, id_ok}, {31'd0, e.id_ok});
                    check("sb_ts_ok", {31'd0, ts_ok}, {31'd0, e.ts_ok});
                    check("sb_timed_out", {31'd0, timed_out}, {31'd0, e.timed_out});
                    check("sb_id_value", id_value, e.id_value);
                    check("sb_ts_value", ts_value, e.ts_value);
                end
            end
        end
    end

    // Bus protocol: a stalled request must hold read and address.
    initial begin : protocol
        logic prev_read = 1'b0;
        logic prev_addr = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && prev_read && avm_waitrequest) begin
                check("read_held_in_stall", {31'd0, avm_read}, 32'd1);
                check("addr_held_in_stall", {31'd0, avm_address}, {31'd0, prev_addr});
            end
            if (avm_read) check("read_only_when_busy", {31'd0, busy}, 32'd1);
            prev_read = avm_read;
            prev_addr = avm_address;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int k;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state.
        @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_id_ok", {31'd0, id_ok}, 32'd0);
        check("rst_ts_ok", {31'd0, ts_ok}, 32'd0);
        check("rst_timed_out", {31'd0, timed_out}, 32'd0);
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_addr", {31'd0, avm_address}, 32'd0);
        check("rst_id_value", id_value, 32'd0);
        check("rst_ts_value", ts_value, 32'd0);

        // 1: auto start, zero-wait same-cycle responses.
        @(negedge clock);
        n = done_cnt;
        push_exp(1'b1, 1'b1, 1'b0, ID_WORD, TS_WORD);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_read_id", {31'd0, avm_read}, 32'd1);
        check("t1_addr_id", {31'd0, avm_address}, 32'd0);
        @(posedge clock);
        #1;
        check("t1_read_ts", {31'd0, avm_read}, 32'd1);
        check("t1_addr_ts", {31'd0, avm_address}, 32'd1);
        @(posedge clock);
        #1;
        check("t1_done_latency", {31'd0, done}, 32'd1);
        wait_done(n, 10, "t1_done");
        repeat (4) @(negedge clock);

        // 2: five wait states per read, response one cycle after acceptance.
        cfg_wait = 5;
        cfg_same = 1'b0;
        n = done_cnt;
        push_exp(1'b1, 1'b1, 1'b0, ID_WORD, TS_WORD);
        pulse_start();
        wait_done(n, 60, "t2_done");
        repeat (3) @(negedge clock);

        // 3: wrong ID word; timestamp still read.
        cfg_wait = 0;
        cfg_same = 1'b1;
        cfg_id = 32'h0000_0001;
        n = done_cnt;
        push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0001, TS_WORD);
        pulse_start();
        wait_done(n, 20, "t3_done");
        repeat (3) @(negedge clock);

        // 4: launch clears sticky flags; start while busy is ignored.
        cfg_id = ID_WORD;
        @(negedge clock);
        n = done_cnt;
        push_exp(1'b1, 1'b1, 1'b0, ID_WORD, TS_WORD);
        start = 1'b1;
        @(posedge clock);
        #1;
        check("t4_id_ok_cleared", {31'd0, id_ok}, 32'd0);
        check("t4_ts_ok_cleared", {31'd0, ts_ok}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        check("t4_done_latency", {31'd0, done}, 32'd1);
        wait_done(n, 10, "t4_done");
        repeat (8) @(posedge clock);
        #2;
        check("t4_single_done", done_cnt, n + 1);
        repeat (2) @(negedge clock);

`ifdef SYSID_CHECKER_TIMEOUT_EN
        // 5: slave stalls forever; abort after 16 cycles of request.
        cfg_wait = 1000;
        @(negedge clock);
        n = done_cnt;
        push_exp(1'b0, 1'b0, 1'b1, ID_WORD, TS_WORD);
        start = 1'b1;
        @(posedge clock);
        #1;
        k = avm_read ? 1 : 0;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clock);
            #1;
            if (avm_read) k++;
        end
        check("t5_read_cycles", k, 16);
        check("t5_read_low_at_done", {31'd0, avm_read}, 32'd0);
        wait_done(n, 5, "t5_done");
        cfg_wait = 0;
        repeat (3) @(negedge clock);
`endif

        // 6: reset while waiting for the timestamp; late responses ignored.
        cfg_resp_ts = 1'b0;
        pulse_start();
        k = 0;
        while (!id_ok && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("t6_id_captured", {31'd0, id_ok}, 32'd1);
        repeat (2) @(negedge clock);
        check("t6_waiting_busy", {31'd0, busy}, 32'd1);
        check("t6_waiting_no_read", {31'd0, avm_read}, 32'd0);
        reset = 1'b1;
        cfg_resp_ts = 1'b1;
        inject_data = ID_WORD;
        inject_until = cyc + 3;
        push_exp(1'b1, 1'b1, 1'b0, ID_WORD, TS_WORD);
        @(posedge clock);
        #1;
        check("t6_rst_read", {31'd0, avm_read}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_id_ok", {31'd0, id_ok}, 32'd0);
        check("t6_rst_id_value", id_value, 32'd0);
        @(posedge clock);
        #1;
        check("t6_rst_late_id_ok", {31'd0, id_ok}, 32'd0);
        check("t6_rst_late_ts_value", ts_value, 32'd0);
        @(negedge clock);
        n = done_cnt;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("t6_idle_late_id_ok", {31'd0, id_ok}, 32'd0);
        check("t6_idle_late_id_value", id_value, 32'd0);
        check("t6_relaunch_busy", {31'd0, busy}, 32'd1);
        check("t6_relaunch_read", {31'd0, avm_read}, 32'd1);
        wait_done(n, 20, "t6_done");
        repeat (4) @(posedge clock);
        #2;
        check("exp_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
